line_pwm_ctrl: RTL
==================

# line_pwm_ctrl

Parametrised motor speed and steering controller for the line-following car. It samples an N-bit reflective line-sensor vector on a slow update tick and adjusts a saturating base speed. It derives a differential left/right duty and generates two glitch-free PWM outputs for the motor driver. It replaces the fixed 5-sensor, single-duty controller and adds per-wheel steering, parametrised geometry and a single-cycle clamp.

## Interface
- `SENSOR_W`, 5: sensor count; odd, ≥3; centre index `C = SENSOR_W/2`.
- `TICK_DIV`, 8_000_000: clk cycles per speed-update tick; ≥2.
- `PWM_PERIOD`, 100: PWM counter period in clk cycles; ≥4.
- `DUTY_W`, 8: duty width; must hold `PWM_PERIOD`.
- `DUTY_MIN`, 30: lower bound of the base speed.
- `DUTY_MAX`, 100: upper bound of the base speed; `DUTY_MIN` ≤ `DUTY_MAX` ≤ `PWM_PERIOD`.
- `DUTY_PARK`, 50: base speed while parking, on reset, and on cross-line.
- `STEP_FAST`, 15: base increment on a clean centre-only reading.
- `STEP_LOST`, 10: base increment when no sensor is lit.
- `STEP_TURN`, 5: base decrement per unit of imbalance.
- `STEER_GAIN`, 8: duty offset per unit of imbalance.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `sensor` in `SENSOR_W`: line sensors; 1 = line seen; bit `SENSOR_W-1` = leftmost.
- `pwm_en` in 1: motor enable.
- `park` in 2: parking-mode code; any nonzero value means parking.
- `pwm1` out 1: left motor PWM.
- `pwm2` out 1: right motor PWM.
- `duty_l` out `DUTY_W`: active left duty, for debug and telemetry.
- `duty_r` out `DUTY_W`: active right duty, for debug and telemetry.
- `tick` out 1: one-cycle pulse on each speed update.

## Operation
- Tick counter `tcnt` counts 0..`TICK_DIV-1`. `tick` = 1 for the cycle `tcnt == TICK_DIV-1`. It free-runs regardless of `pwm_en`.
- Classification (combinational):
  - `L` = popcount of `sensor[SENSOR_W-1:C+1]`.
  - `R` = popcount of `sensor[C-1:0]`.
  - `e = L − R`, signed, `$clog2(SENSOR_W)+1` bits.
- Base update on `tick`, evaluated in priority order, first match wins:
  1. `park != 0` → `base = DUTY_PARK`.
  2. All sensors 1 (cross-line) → `base = DUTY_PARK`.
  3. All sensors 0 (lost) → `base += STEP_LOST`.
  4. Only bit C set → `base += STEP_FAST`.
  5. Otherwise → `base −= |e|·STEP_TURN`.
- Base arithmetic:
  - Computed in `DUTY_W+2` signed bits.
  - The result is clamped to [`DUTY_MIN`,`DUTY_MAX`] in the same update, so an out-of-range value is never stored.
- Steer on `tick`:
  - `steer = e·STEER_GAIN` in cases 4 and 5.
  - `steer = 0` in cases 1–3.
- Wheel duty:
  - Pending left = `clamp(base − steer, 0, PWM_PERIOD)`; pending right = `clamp(base + steer, 0, PWM_PERIOD)`.
  - Line to the left (e>0) therefore slows the left wheel.
- PWM generation:
  - Counter `pcnt` counts 0..`PWM_PERIOD-1`.
  - Active duties `duty_l`/`duty_r` load from the pending values only when `pcnt == PWM_PERIOD-1`, so no period is ever truncated.
  - `pwm1 = (pcnt < duty_l)` and `pwm2 = (pcnt < duty_r)`, both registered.
  - Duty 0 gives a constant low output; duty `PWM_PERIOD` gives a constant high output.
- `pwm_en = 0`:
  - `pcnt` is held at 0 and `pwm1`/`pwm2` are forced to 0.
  - Base/steer updates continue.
  - On re-enable, the first period starts at `pcnt = 0` with the current active duties.
- `park` mid-period: it takes effect at the next `tick`. It never forces the outputs directly.

## Timing
- Reset values:
  - `tcnt`, `pcnt`, `steer` = 0.
  - `base` = `DUTY_PARK`.
  - `duty_l` = `duty_r` = `DUTY_PARK`.
  - `pwm1` = `pwm2` = 0.
  - `tick` = 0.
- Reset mid-operation returns every register to these values immediately (asynchronous). The first `tick` follows `TICK_DIV` cycles after deassertion.
- Update latency:
  - `base`/`steer` register on the clk edge ending the `tick` cycle.
  - Pending duty is combinational from those registers.
  - Active duty loads at the next `pcnt` wrap.
- Worst-case latency from sensor sample to PWM change is `PWM_PERIOD + 1` cycles after `tick`.
- PWM output is the registered compare, so it lags `pcnt` by 1 cycle. Period is exactly `PWM_PERIOD` cycles.
- A `tick` and a `pcnt` wrap in the same cycle: the wrap loads the old pending value. The new value waits for the next wrap.

## Structure
- Shared package `line_ctrl_pkg` holds:
  - `class_e` enum: PARK, CROSS, LOST, CENTRE, TURN.
  - The `sat_clamp` function (signed value, lo, hi).
  - The popcount function.
- Sub-module `line_classify` is combinational: `sensor`, `park` → `class_e`, `e`.
- The top module holds the tick counter, the base/steer registers and two PWM compare channels. The compare logic is written once as a two-iteration generate loop.

## Test plan
All scenarios use `TICK_DIV`=20, `PWM_PERIOD`=100 and all other parameters at default.
- Reset, then `pwm_en`=1 with `sensor`=00100 held → base 50→65→80→95→100 and stays at 100. `duty_l`=`duty_r` track base one wrap later. `pwm1` is high exactly `duty` cycles per 100.
- `sensor`=11000 from base 80 → e=2, base=70, steer=16 → `duty_l`=54, `duty_r`=86. A further tick gives base 60, `duty_l`=44, `duty_r`=76.
- `sensor`=00000 from base 95 → base 100 after one tick (clamp, not 105). `sensor`=11111 → base 50, steer 0.
- `park`=2'b01 with `sensor`=11100 → base=50, both duties 50, no steering. `park` returns to 0 → steering resumes on the next tick.
- `pwm_en` dropped mid-period at `pcnt`=37 → `pwm1`/`pwm2` go low next cycle. On re-enable, the high phase restarts from `pcnt`=0 with the full duty.
- `rst_n` pulsed low for 1 cycle while base=100 → all registers return to their reset values immediately. `pwm1`/`pwm2` = 0. First `tick` arrives 20 cycles after release.

Source files
------------

// File: rtl/line_ctrl_pkg.sv
// line_ctrl_pkg
// Shared types and helpers for the line-following motor controller.
//   class_e   : sensor reading classification, in priority order
//   sat_clamp : saturate a signed integer into [lo, hi]
//   popcount  : number of set bits in a (zero-extended) vector
package line_ctrl_pkg;

  typedef enum logic [2:0] {
    PARK,
    CROSS,
    LOST,
    CENTRE,
    TURN
  } class_e;

  function automatic int sat_clamp(input int value, input int lo, input int hi);
    if (value < lo) return lo;
    if (value > hi) return hi;
    return value;
  endfunction

  function automatic int popcount(input logic [31:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 32; i++) n = n + int'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/line_classify.sv
// line_classify
// Combinational classification of the line-sensor vector.
// Ports:
//   i_sensor : sensor vector, bit SENSOR_W-1 is the leftmost sensor
//   i_park   : parking code, any nonzero value means parking
//   o_class  : reading class (PARK > CROSS > LOST > CENTRE > TURN)
//   o_e      : signed imbalance, lit-left minus lit-right (centre excluded)
module line_classify
  import line_ctrl_pkg::*;
#(
  parameter int SENSOR_W = 5,
  parameter int E_W      = $clog2(SENSOR_W) + 1
) (
  input  logic [SENSOR_W-1:0]  i_sensor,
  input  logic [1:0]           i_park,
  output class_e               o_class,
  output logic signed [E_W-1:0] o_e
);

  localparam int C = SENSOR_W / 2;
  localparam logic [SENSOR_W-1:0] CENTRE_ONLY = {{(SENSOR_W-1){1'b0}}, 1'b1} << C;

  int w_left;
  int w_right;

  // Count lit sensors either side of the centre and pick the first matching class
  always_comb begin
    w_left  = popcount(32'(i_sensor[SENSOR_W-1:C+1]));
    w_right = popcount(32'(i_sensor[C-1:0]));
    o_e     = E_W'(w_left - w_right);
    o_class = TURN;
    if (i_park != 2'b00)              o_class = PARK;
    else if (&i_sensor)               o_class = CROSS;
    else if (i_sensor == '0)          o_class = LOST;
    else if (i_sensor == CENTRE_ONLY) o_class = CENTRE;
  end

endmodule

// File: rtl/line_pwm_ctrl.sv
// line_pwm_ctrl
// Speed and steering controller for the line-following car. A slow tick
// updates a saturating base speed and a steering offset from the sensors;
// two PWM channels turn base -/+ steer into left/right motor drive.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   sensor         : line sensors, 1 = line seen, MSB = leftmost
//   pwm_en         : motor enable; when low the PWM counter parks at 0
//   park           : nonzero requests parking speed at the next tick
//   pwm1, pwm2     : left / right motor PWM (registered)
//   duty_l, duty_r : active left / right duty
//   tick           : one-cycle pulse marking each speed update
module line_pwm_ctrl
  import line_ctrl_pkg::*;
#(
  parameter int SENSOR_W   = 5,
  parameter int TICK_DIV   = 8_000_000,
  parameter int PWM_PERIOD = 100,
  parameter int DUTY_W     = 8,
  parameter int DUTY_MIN   = 30,
  parameter int DUTY_MAX   = 100,
  parameter int DUTY_PARK  = 50,
  parameter int STEP_FAST  = 15,
  parameter int STEP_LOST  = 10,
  parameter int STEP_TURN  = 5,
  parameter int STEER_GAIN = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SENSOR_W-1:0] sensor,
  input  logic                pwm_en,
  input  logic [1:0]          park,
  output logic                pwm1,
  output logic                pwm2,
  output logic [DUTY_W-1:0]   duty_l,
  output logic [DUTY_W-1:0]   duty_r,
  output logic                tick
);

  localparam int E_W = $clog2(SENSOR_W) + 1;
  localparam int T_W = $clog2(TICK_DIV);
  localparam int P_W = $clog2(PWM_PERIOD);
  localparam int B_W = DUTY_W + 2;

  logic [T_W-1:0]        r_tcnt;
  logic [P_W-1:0]        r_pcnt;
  logic [DUTY_W-1:0]     r_base;
  logic signed [B_W-1:0] r_steer;

  class_e                w_class;
  logic signed [E_W-1:0] w_e;
  int                    w_absE;
  logic signed [B_W-1:0] w_baseRaw;
  logic signed [B_W-1:0] w_steerNext;
  logic [DUTY_W-1:0]     w_baseNext;
  logic [DUTY_W-1:0]     w_pend [2];
  logic                  w_tick;
  logic                  w_wrap;

  line_classify #(
    .SENSOR_W (SENSOR_W),
    .E_W      (E_W)
  ) u_classify (
    .i_sensor (sensor),
    .i_park   (park),
    .o_class  (w_class),
    .o_e      (w_e)
  );

  assign w_tick = (r_tcnt == T_W'(TICK_DIV - 1));
  assign w_wrap = (r_pcnt == P_W'(PWM_PERIOD - 1));
  assign tick   = w_tick;
  assign w_absE = (w_e < 0) ? -int'(w_e) : int'(w_e);

  // Free-running update tick, independent of the motor enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_tcnt <= '0;
    else if (w_tick) r_tcnt <= '0;
    else             r_tcnt <= r_tcnt + T_W'(1);
  end

  // Next base/steer; the raw sum is clamped before it can ever be stored
  always_comb begin
    w_baseRaw   = B_W'(DUTY_PARK);
    w_steerNext = '0;
    case (w_class)
      PARK, CROSS: w_baseRaw = B_W'(DUTY_PARK);
      LOST:        w_baseRaw = B_W'(int'(r_base) + STEP_LOST);
      CENTRE: begin
        w_baseRaw   = B_W'(int'(r_base) + STEP_FAST);
        w_steerNext = B_W'(int'(w_e) * STEER_GAIN);
      end
      TURN: begin
        w_baseRaw   = B_W'(int'(r_base) - w_absE * STEP_TURN);
        w_steerNext = B_W'(int'(w_e) * STEER_GAIN);
      end
      default: ;
    endcase
    w_baseNext = DUTY_W'(sat_clamp(int'(w_baseRaw), DUTY_MIN, DUTY_MAX));
  end

  // Base speed and steering register only on the tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_base  <= DUTY_W'(DUTY_PARK);
      r_steer <= '0;
    end else if (w_tick) begin
      r_base  <= w_baseNext;
      r_steer <= w_steerNext;
    end
  end

  // Positive steer means line to the left, so the left wheel slows
  always_comb begin
    w_pend[0] = DUTY_W'(sat_clamp(int'(r_base) - int'(r_steer), 0, PWM_PERIOD));
    w_pend[1] = DUTY_W'(sat_clamp(int'(r_base) + int'(r_steer), 0, PWM_PERIOD));
  end

  // PWM period counter, parked at 0 while the motors are disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_pcnt <= '0;
    else if (!pwm_en) r_pcnt <= '0;
    else if (w_wrap)  r_pcnt <= '0;
    else              r_pcnt <= r_pcnt + P_W'(1);
  end

  // Per-wheel compare; duty reloads only on the wrap so no period is cut short
  for (genvar i = 0; i < 2; i++) begin : g_ch
    logic [DUTY_W-1:0] r_duty;
    logic              r_pwm;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_duty <= DUTY_W'(DUTY_PARK);
        r_pwm  <= 1'b0;
      end else begin
        if (w_wrap) r_duty <= w_pend[i];
        r_pwm <= pwm_en && (DUTY_W'(r_pcnt) < r_duty);
      end
    end
  end

  assign duty_l = g_ch[0].r_duty;
  assign duty_r = g_ch[1].r_duty;
  assign pwm1   = g_ch[0].r_pwm;
  assign pwm2   = g_ch[1].r_pwm;

endmodule
